io_rx_fifo_mark: RTL
====================

IO_RX_FIFO_MARK -- requirements
Module: io_rx_fifo_mark

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the data word.
REQ-002 SHALL have parameter BUFFER_DEPTH, default 4, number of FIFO entries (power of two, at least 2).
REQ-003 SHALL have parameter LOG_BUFFER_DEPTH, default log2(BUFFER_DEPTH), pointer width.
REQ-004 SHALL have port clk_i, input, 1, clock; all logic rising-edge.
REQ-005 SHALL have port rstn_i, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port clr_i, input, 1, synchronous flush.
REQ-007 SHALL have ports valid_i (in, 1), data_i (in, DATA_WIDTH), sof_i (in, 1), eof_i (in, 1), ready_o (out, 1): peripheral push side; sof_i and eof_i qualify the pushed word.
REQ-008 SHALL have ports valid_o (out, 1), data_o (out, DATA_WIDTH), ready_i (in, 1): uDMA RX pop side.
REQ-009 SHALL have ports sof_evt_o (out, 1) and eof_evt_o (out, 1): single-cycle pulses on pop of a frame's first and last word.
REQ-010 SHALL have port elements_o, out, LOG_BUFFER_DEPTH+1, current occupancy.
REQ-011 SHALL have port frames_o, out, LOG_BUFFER_DEPTH+1, complete frames (eof-marked words) held in the FIFO.
REQ-012 SHALL have port len_o, out, 16, word length of the last completed frame.
REQ-013 SHALL have port err_o, out, 1, single-cycle framing-error pulse.

Function
REQ-014 SHALL store {eof_i, sof_i, data_i} per entry in an internal circular buffer with read/write pointers wrapping at BUFFER_DEPTH.
REQ-015 SHALL assert ready_o = (elements_o != BUFFER_DEPTH); push = valid_i & ready_o.
REQ-016 SHALL assert valid_o = (elements_o != 0); pop = valid_o & ready_i; data_o is the head entry data.
REQ-017 SHALL give latency of exactly 1 cycle from push to valid_o on an empty FIFO; no combinational bypass.
REQ-018 SHALL update elements_o +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-019 SHALL register sof_evt_o/eof_evt_o: high in the cycle after a pop whose head entry carried sof/eof, low otherwise.
REQ-020 SHALL implement a frame FSM, states IDLE and IN_FRAME, advancing on push only.
REQ-021 IDLE: push with sof_i & ~eof_i -> IN_FRAME; push with sof_i & eof_i -> stay IDLE, single-word frame complete.
REQ-022 IDLE: push with ~sof_i -> err_o pulse next cycle, word still stored; with eof_i stay IDLE, frame not counted; without eof_i -> IN_FRAME (recovery).
REQ-023 IN_FRAME: push with eof_i & ~sof_i -> IDLE, frame complete; push with sof_i -> err_o pulse, word-count restarts at 1 (eof_i also set -> IDLE, frame complete, length 1).
REQ-024 SHALL count words pushed in the current frame (16 bit, saturating at 0xFFFF, sof word = 1); on frame complete capture count into len_o the next cycle.
REQ-025 SHALL increment frames_o on frame-complete push, decrement on pop of an eof-marked word, hold when both occur in the same cycle.
REQ-026 SHALL keep pointers, elements_o and frames_o consistent across wrap-around; frames_o never exceeds elements_o.

Reset
REQ-027 SHALL on rstn_i low: pointers 0, elements_o 0, frames_o 0, len_o 0, FSM IDLE, word-count 0, valid_o 0, ready_o 1, sof_evt_o/eof_evt_o/err_o 0.
REQ-028 SHALL on clr_i high apply the same values as REQ-027 at the next edge, with priority over simultaneous push/pop; no event or error pulse generated by the cleared cycle.
REQ-029 SHALL not require storage contents to be reset.

Verification
REQ-030 Push 3 words A,B,C with sof on A, eof on C, ready_i=0, then ready_i=1 -> frames_o=1, len_o=3, pops A,B,C in order, sof_evt_o after A, eof_evt_o after C, frames_o 0.
REQ-031 DEPTH=4, ready_i=0, push 5 words -> ready_o=0 after 4th, elements_o=4, 5th held; pop 1 -> 5th accepted next cycle.
REQ-032 Single word with sof_i=eof_i=1 -> frames_o=1, len_o=1, one pop gives sof_evt_o and eof_evt_o both pulsing in the same cycle.
REQ-033 Push word without sof in IDLE -> err_o one-cycle pulse, elements_o=1, frames_o=0; sof during IN_FRAME -> err_o pulse, next eof gives len_o counted from new sof.
REQ-034 Full FIFO, simultaneous eof push and eof pop with continuous streaming over 3 wraps -> elements_o and frames_o stable, data order preserved.
REQ-035 clr_i asserted mid-frame with elements_o=3 -> next cycle elements_o=0, frames_o=0, valid_o=0, FSM IDLE; next sof-less word raises err_o.

Source files
------------

// File: rtl/io_rx_fifo_mark.sv
// io_rx_fifo_mark: RX FIFO with sof/eof framing marks, frame counting, length capture and framing-error detection.
module io_rx_fifo_mark #(
    parameter int DATA_WIDTH       = 32,
    parameter int BUFFER_DEPTH     = 4,
    parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        clr_i,
    input  logic                        valid_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic                        sof_i,
    input  logic                        eof_i,
    output logic                        ready_o,
    output logic                        valid_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    input  logic                        ready_i,
    output logic                        sof_evt_o,
    output logic                        eof_evt_o,
    output logic [LOG_BUFFER_DEPTH:0]   elements_o,
    output logic [LOG_BUFFER_DEPTH:0]   frames_o,
    output logic [15:0]                 len_o,
    output logic                        err_o
);
    typedef enum logic {IDLE, IN_FRAME} state_e;
    localparam int EW = DATA_WIDTH + 3;
    localparam int PW = LOG_BUFFER_DEPTH;
    localparam int CW = LOG_BUFFER_DEPTH + 1;
    localparam logic [LOG_BUFFER_DEPTH:0] FULL = CW'(BUFFER_DEPTH);
    // Each entry also keeps a "done" bit so only eof words that completed a counted frame decrement frames_o.
    logic [EW-1:0]             mem_q [BUFFER_DEPTH];
    logic [EW-1:0]             head;
    logic [PW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LOG_BUFFER_DEPTH:0] elements_q, elements_d, frames_q, frames_d;
    logic [15:0]               cnt_q, cnt_d, len_q, len_d, cnt_new;
    state_e                    state_q, state_d;
    logic                      sof_evt_q, sof_evt_d, eof_evt_q, eof_evt_d, err_q, err_d;
    logic                      push, pop, complete;

    assign ready_o    = elements_q != FULL;
    assign valid_o    = elements_q != '0;
    assign push       = valid_i & ready_o;
    assign pop        = valid_o & ready_i;
    assign head       = mem_q[rptr_q];
    assign data_o     = head[DATA_WIDTH-1:0];
    assign elements_o = elements_q;
    assign frames_o   = frames_q;
    assign len_o      = len_q;
    assign sof_evt_o  = sof_evt_q;
    assign eof_evt_o  = eof_evt_q;
    assign err_o      = err_q;

    always_comb begin
        complete   = push & eof_i & ((state_q == IN_FRAME) | sof_i);
        cnt_new    = (state_q == IDLE || sof_i) ? 16'd1 : (cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1);
        wptr_d     = clr_i ? '0 : wptr_q + PW'(push);
        rptr_d     = clr_i ? '0 : rptr_q + PW'(pop);
        elements_d = clr_i ? '0 : elements_q + CW'(push) - CW'(pop);
        frames_d   = clr_i ? '0 : frames_q + CW'(complete) - CW'(pop & head[DATA_WIDTH+2]);
        state_d    = clr_i ? IDLE : push ? (eof_i ? IDLE : IN_FRAME) : state_q;
        cnt_d      = clr_i ? '0 : push ? cnt_new : cnt_q;
        len_d      = clr_i ? '0 : complete ? cnt_new : len_q;
        err_d      = ~clr_i & push & (state_q == IDLE ? ~sof_i : sof_i);
        sof_evt_d  = ~clr_i & pop & head[DATA_WIDTH];
        eof_evt_d  = ~clr_i & pop & head[DATA_WIDTH+1];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            elements_q <= '0;
            frames_q   <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            sof_evt_q  <= 1'b0;
            eof_evt_q  <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            elements_q <= elements_d;
            frames_q   <= frames_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            err_q      <= err_d;
            sof_evt_q  <= sof_evt_d;
            eof_evt_q  <= eof_evt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !clr_i) mem_q[wptr_q] <= {complete, eof_i, sof_i, data_i};
    end
endmodule
